// File: rtl/atm_account_store.sv
// Account-database responder for the ATM controller: sequential table scan, balance update, valid/ready request and response.
// Optional macro ATM_PIN_LOCKOUT_EN adds a per-account failed-PIN counter that locks the account at 3 failures.
module atm_account_store #(
  parameter int NUM_ACCOUNTS    = 8,
  parameter int ACC_W           = 12,
  parameter int PIN_W           = 4,
  parameter int BAL_W           = 11,
  parameter int AMT_W           = 12,
  parameter int DEFAULT_BALANCE = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [1:0]       reqOp,
  input  logic [ACC_W-1:0] reqAccNumber,
  input  logic [PIN_W-1:0] reqPin,
  input  logic [AMT_W-1:0] reqAmount,
  output logic             respValid,
  input  logic             respReady,
  output logic             respFound,
  output logic             respAuth,
  output logic             respError,
  output logic [BAL_W-1:0] respBalance
);

  typedef enum logic [1:0] {IDLE, SCAN, EXEC, RESP} state_t;

  localparam int IDX_W = $clog2(NUM_ACCOUNTS);
  localparam int SUM_W = ((AMT_W > BAL_W) ? AMT_W : BAL_W) + 1;
  localparam logic [1:0] OP_FIND = 2'b00, OP_AUTH = 2'b01, OP_DEBIT = 2'b10, OP_CREDIT = 2'b11;

  function automatic logic [ACC_W-1:0] acc_of(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       return ACC_W'(2749);
      1:       return ACC_W'(2175);
      2:       return ACC_W'(2429);
      3:       return ACC_W'(2514);
      4:       return ACC_W'(2178);
      5:       return ACC_W'(2893);
      6:       return ACC_W'(2816);
      7:       return ACC_W'(2351);
      default: return '0;
    endcase
  endfunction

  // Each entry's PIN equals its table index.
  function automatic logic [PIN_W-1:0] pin_of(input logic [IDX_W-1:0] i);
    return PIN_W'(i);
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic             found_q;
  logic [BAL_W-1:0] bal [NUM_ACCOUNTS];
  logic [1:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [AMT_W-1:0] amt_q;
`ifdef ATM_PIN_LOCKOUT_EN
  logic [1:0]       fails [NUM_ACCOUNTS];
`endif

  logic             pin_eq, locked, auth_ok, debit_ok, credit_ok;
  logic [BAL_W-1:0] cur_bal, new_bal, x_bal;
  logic [SUM_W-1:0] sum;
  logic             x_auth, x_err, wr_en;

  // Result of the EXEC cycle, computed from the latched request and matched entry.
  always_comb begin
    cur_bal   = bal[idx_q];
    pin_eq    = (pin_q == pin_of(idx_q));
`ifdef ATM_PIN_LOCKOUT_EN
    locked    = (fails[idx_q] == 2'd3);
`else
    locked    = 1'b0;
`endif
    auth_ok   = found_q && pin_eq && !locked;
    sum       = SUM_W'(cur_bal) + SUM_W'(amt_q);
    debit_ok  = auth_ok && (SUM_W'(amt_q) <= SUM_W'(cur_bal));
    credit_ok = found_q && (sum <= SUM_W'((2 ** BAL_W) - 1));
    new_bal   = cur_bal;
    x_auth    = 1'b0;
    x_err     = 1'b0;
    wr_en     = 1'b0;
    case (op_q)
      OP_FIND: x_err = !found_q;
      OP_AUTH: begin
        x_auth = auth_ok;
        x_err  = !auth_ok;
      end
      OP_DEBIT: begin
        x_auth = auth_ok;
        x_err  = !debit_ok;
        wr_en  = debit_ok;
        new_bal = cur_bal - BAL_W'(amt_q);
      end
      default: begin
        x_err   = !credit_ok;
        wr_en   = credit_ok;
        new_bal = sum[BAL_W-1:0];
      end
    endcase
    x_bal = found_q ? (wr_en ? new_bal : cur_bal) : '0;
  end

  // Request fields are plain data, captured only on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && reqValid && reqReady) begin
      op_q  <= reqOp;
      acc_q <= reqAccNumber;
      pin_q <= reqPin;
      amt_q <= reqAmount;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      reqReady    <= 1'b1;
      respValid   <= 1'b0;
      respFound   <= 1'b0;
      respAuth    <= 1'b0;
      respError   <= 1'b0;
      respBalance <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i] <= BAL_W'(DEFAULT_BALANCE);
`ifdef ATM_PIN_LOCKOUT_EN
        fails[i] <= 2'd0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            idx_q    <= '0;
            found_q  <= 1'b0;
            reqReady <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (acc_of(idx_q) == acc_q) begin
            found_q <= 1'b1;
            state   <= EXEC;
          end else if (idx_q == IDX_W'(NUM_ACCOUNTS - 1)) begin
            state <= EXEC;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        EXEC: begin
          respValid   <= 1'b1;
          respFound   <= found_q;
          respAuth    <= x_auth;
          respError   <= x_err;
          respBalance <= x_bal;
          if (wr_en) bal[idx_q] <= new_bal;
`ifdef ATM_PIN_LOCKOUT_EN
          if (found_q && (op_q == OP_AUTH || op_q == OP_DEBIT)) begin
            if (!pin_eq && fails[idx_q] != 2'd3) fails[idx_q] <= fails[idx_q] + 2'd1;
            else if (pin_eq && !locked)          fails[idx_q] <= 2'd0;
          end
`endif
          state <= RESP;
        end
        default: begin
          if (respValid && respReady) begin
            respValid   <= 1'b0;
            respFound   <= 1'b0;
            respAuth    <= 1'b0;
            respError   <= 1'b0;
            respBalance <= '0;
            reqReady    <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_store.sv
// Self-checking bench for atm_account_store: directed scenarios plus randomized requests against a behavioural account model.
module tb_atm_account_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [1:0]  reqOp = 2'b00;
  logic [11:0] reqAccNumber = '0;
  logic [3:0]  reqPin = '0;
  logic [11:0] reqAmount = '0;
  logic        respValid;
  logic        respReady = 1'b1;
  logic        respFound, respAuth, respError;
  logic [10:0] respBalance;

  always #5 clk = ~clk;

  atm_account_store dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqAccNumber(reqAccNumber), .reqPin(reqPin), .reqAmount(reqAmount),
    .respValid(respValid), .respReady(respReady), .respFound(respFound),
    .respAuth(respAuth), .respError(respError), .respBalance(respBalance)
  );

`ifdef ATM_PIN_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam int ACCS [8] = '{2749, 2175, 2429, 2514, 2178, 2893, 2816, 2351};

  int ntests = 0;
  int nfail  = 0;
  int mbal  [8];
  int mfail [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mbal[i]  = 500;
      mfail[i] = 0;
    end
  endtask

  // Account-level semantics: look up, check PIN/lock, apply money rules.
  task automatic model_op(input int op, input int acc, input int pin, input int amt,
                          output int f, output int a, output int e, output int b, output int lat);
    int  k;
    bit  locked, pin_ok;
    k = -1;
    for (int i = 0; i < 8; i++) if (k < 0 && ACCS[i] == acc) k = i;
    f = (k >= 0);
    a = 0;
    e = 0;
    lat = f ? k + 2 : 9;
    locked = f && LOCK && mfail[k] >= 3;
    pin_ok = f && (pin == k);
    case (op)
      0: e = !f;
      1, 2: begin
        a = pin_ok && !locked;
        if (LOCK && f) begin
          if (!pin_ok) mfail[k] = (mfail[k] >= 3) ? 3 : mfail[k] + 1;
          else if (!locked) mfail[k] = 0;
        end
        if (op == 1) e = !a;
        else if (a && amt <= mbal[k]) mbal[k] = mbal[k] - amt;
        else e = 1;
      end
      default: begin
        if (f && mbal[k] + amt <= 2047) mbal[k] = mbal[k] + amt;
        else e = 1;
      end
    endcase
    b = f ? mbal[k] : 0;
  endtask

  task automatic do_req(input int op, input int acc, input int pin, input int amt,
                        output int of, output int oa, output int oe, output int ob);
    int ef, ea, ee, eb, elat, cyc;
    bit got;
    cyc = 0;
    while (!reqReady && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    reqValid = 1'b1;
    reqOp = op[1:0];
    reqAccNumber = acc[11:0];
    reqPin = pin[3:0];
    reqAmount = amt[11:0];
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqOp = 2'($urandom);
    reqAccNumber = 12'($urandom);
    reqPin = 4'($urandom);
    reqAmount = 12'($urandom);
    model_op(op, acc, pin, amt, ef, ea, ee, eb, elat);
    got = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (respValid) begin
        got = 1'b1;
        break;
      end
    end
    of = respFound; oa = respAuth; oe = respError; ob = respBalance;
    ntests++;
    if (!got || cyc != elat) begin
      nfail++;
      $display("FAIL latency op=%0d acc=%0d: got %0d cycles (valid=%0b), want %0d", op, acc, cyc, got, elat);
    end
    if (!got) return;
    ntests++;
    if (of != ef || oa != ea || oe != ee || ob != eb) begin
      nfail++;
      $display("FAIL resp op=%0d acc=%0d pin=%0d amt=%0d: got f%0d a%0d e%0d b%0d, want f%0d a%0d e%0d b%0d",
               op, acc, pin, amt, of, oa, oe, ob, ef, ea, ee, eb);
    end
    if (respReady) begin
      @(posedge clk); #1;
      ntests++;
      if (reqReady !== 1'b1 || respValid !== 1'b0 || respBalance !== '0) begin
        nfail++;
        $display("FAIL back_to_back: reqReady=%0b respValid=%0b bal=%0d, want 1 0 0", reqReady, respValid, respBalance);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ntests++;
    if (reqReady !== 1'b1 || respValid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_hs: reqReady=%0b respValid=%0b, want 1 0", reqReady, respValid);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    ntests++;
    if ({respFound, respAuth, respError} !== 3'b000 || respBalance !== 11'd0 || reqReady !== 1'b1) begin
      nfail++;
      $display("FAIL reset_out: f%0b a%0b e%0b b%0d rdy%0b, want 0 0 0 0 1",
               respFound, respAuth, respError, respBalance, reqReady);
    end
  endtask

  task automatic test_directed();
    int f, a, e, b;
    do_req(1, 2278, 4, 0, f, a, e, b);
    do_req(1, 2178, 4, 0, f, a, e, b);
    ntests++;
    if (b != 500 || a != 1) begin nfail++; $display("FAIL auth_2178: bal %0d auth %0d, want 500 1", b, a); end
    do_req(2, 2178, 4, 100, f, a, e, b);
    ntests++;
    if (b != 400 || e != 0) begin nfail++; $display("FAIL debit_100: bal %0d err %0d, want 400 0", b, e); end
    do_req(2, 2178, 4, 2500, f, a, e, b);
    do_req(0, 2178, 0, 0, f, a, e, b);
    ntests++;
    if (b != 400) begin nfail++; $display("FAIL find_after_debit: bal %0d, want 400", b); end
    do_req(3, 2816, 9, 50, f, a, e, b);
    ntests++;
    if (b != 550 || e != 0) begin nfail++; $display("FAIL credit_50: bal %0d err %0d, want 550 0", b, e); end
    do_req(3, 2816, 0, 2550, f, a, e, b);
    do_req(3, 2816, 0, 0, f, a, e, b);
    do_req(1, 2816, 6, 0, f, a, e, b);
    ntests++;
    if (b != 550) begin nfail++; $display("FAIL persist_2816: bal %0d, want 550", b); end
    do_req(3, 2749, 0, 1547, f, a, e, b);
    do_req(3, 2749, 0, 1, f, a, e, b);
    do_req(2, 2749, 0, 2047, f, a, e, b);
  endtask

  task automatic test_hold();
    int ef, ea, ee, eb, elat, cyc;
    logic [13:0] snap;
    respReady = 1'b0;
    reqValid = 1'b1; reqOp = 2'b00; reqAccNumber = 12'd2429; reqPin = 4'd0; reqAmount = 12'd0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    model_op(0, 2429, 0, 0, ef, ea, ee, eb, elat);
    cyc = 0;
    while (!respValid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    snap = {respFound, respAuth, respError, respBalance};
    ntests++;
    if (snap !== {ef[0], ea[0], ee[0], eb[10:0]}) begin
      nfail++;
      $display("FAIL hold_first: got %h, want %h", snap, {ef[0], ea[0], ee[0], eb[10:0]});
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        reqValid = 1'b1; reqOp = 2'b11; reqAccNumber = 12'd2429; reqAmount = 12'd100;
      end
      @(posedge clk); #1;
      reqValid = 1'b0;
      ntests++;
      if (respValid !== 1'b1 || reqReady !== 1'b0 || {respFound, respAuth, respError, respBalance} !== snap) begin
        nfail++;
        $display("FAIL hold_stable cycle %0d: valid %0b rdy %0b out %h, want 1 0 %h",
                 k, respValid, reqReady, {respFound, respAuth, respError, respBalance}, snap);
      end
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    ntests++;
    if (reqReady !== 1'b1 || respValid !== 1'b0) begin
      nfail++;
      $display("FAIL hold_release: rdy %0b valid %0b, want 1 0", reqReady, respValid);
    end
    do_req(0, 2429, 0, 0, ef, ea, ee, eb);
  endtask

  task automatic test_reset_mid_scan();
    int f, a, e, b;
    reqValid = 1'b1; reqOp = 2'b10; reqAccNumber = 12'd2351; reqPin = 4'd7; reqAmount = 12'd10;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    ntests++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || respBalance !== 11'd0) begin
      nfail++;
      $display("FAIL reset_mid_scan: rdy %0b valid %0b bal %0d, want 1 0 0", reqReady, respValid, respBalance);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_req(0, 2178, 0, 0, f, a, e, b);
    ntests++;
    if (b != 500) begin nfail++; $display("FAIL post_reset_find: bal %0d, want 500", b); end
    do_req(0, 2351, 0, 0, f, a, e, b);
    ntests++;
    if (b != 500) begin nfail++; $display("FAIL dropped_debit: bal %0d, want 500", b); end
  endtask

  task automatic test_lockout();
    int f, a, e, b;
    for (int k = 0; k < 3; k++) do_req(1, 2178, 3, 0, f, a, e, b);
    do_req(1, 2178, 4, 0, f, a, e, b);
    ntests++;
    if (a != (LOCK ? 0 : 1) || e != (LOCK ? 1 : 0)) begin
      nfail++;
      $display("FAIL lockout: auth %0d err %0d, want %0d %0d", a, e, LOCK ? 0 : 1, LOCK ? 1 : 0);
    end
    do_req(3, 2178, 0, 7, f, a, e, b);
  endtask

  task automatic test_random();
    int f, a, e, b, op, acc, pin, amt;
    for (int n = 0; n < 80; n++) begin
      op  = int'($urandom_range(0, 3));
      acc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) : ACCS[$urandom_range(0, 7)];
      pin = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       amt = 0;
        1:       amt = int'($urandom_range(0, 4095));
        default: amt = int'($urandom_range(0, 300));
      endcase
      do_req(op, acc, pin, amt, f, a, e, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_scan();
    test_lockout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
